tex_sampler: RTL and testbench

TEX_SAMPLER -- requirements
Module: tex_sampler

---
 rtl/tex_sampler.sv | 194 +++++++++++++++++++
 tb/tb_tex_sampler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tex_sampler.sv
// Texture sampler: maps a wall hit and screen row to a texel address, divides the
// row offset by the projected wall height, fetches the texel and hands it downstream.
module tex_sampler #(
  parameter int unsigned NUM_TEX     = 4,
  parameter int unsigned TEX_ID_BASE = 3,
  parameter int unsigned TEX_W_LOG2  = 7,
  parameter int unsigned TEX_H_LOG2  = 7,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned ROM_LATENCY = 2
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_n_in,
  input  logic                             req_valid_in,
  output logic                             req_ready_out,
  input  logic [15:0]                      wallX_in,
  input  logic                             flip_in,
  input  logic [7:0]                       lineheight_in,
  input  logic [9:0]                       drawstart_in,
  input  logic [7:0]                       vcount_ray_in,
  input  logic [3:0]                       texture_in,
  output logic [TEX_W_LOG2+TEX_H_LOG2-1:0] rom_addr_out,
  output logic [$clog2(NUM_TEX)-1:0]       rom_sel_out,
  output logic                             rom_en_out,
  input  logic [PIXEL_WIDTH-1:0]           rom_data_in,
  output logic [PIXEL_WIDTH-1:0]           tex_pixel_out,
  output logic                             valid_tex_out,
  input  logic                             out_ready_in
);

  localparam int unsigned TEX_W  = 1 << TEX_W_LOG2;
  localparam int unsigned TEX_H  = 1 << TEX_H_LOG2;
  localparam int unsigned ADDR_W = TEX_W_LOG2 + TEX_H_LOG2;
  localparam int unsigned NUM_W  = 10 + TEX_H_LOG2;
  localparam int unsigned SEL_W  = $clog2(NUM_TEX);
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, DIVIDE, FETCH, OUT} state_t;

  state_t                  state_q, state_d;
  logic [NUM_W-1:0]        num_q, num_d;
  logic [NUM_W-1:0]        quo_q, quo_d;
  logic [7:0]              rem_q, rem_d;
  logic [7:0]              div_q, div_d;
  logic [TEX_W_LOG2-1:0]   u_q, u_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_d;
  logic [SEL_W-1:0]        rom_sel_d;
  logic                    rom_en_d;
  logic [PIXEL_WIDTH-1:0]  pix_d;
  logic                    valid_d;
  logic                    ready_d;

  // Request decode from the live inputs, only consumed on the handshake edge
  logic                    hs_c;
  logic [7:0]              u_shift_c;
  logic [TEX_W_LOG2-1:0]   u_in_c;
  logic [9:0]              off_c;
  logic [NUM_W-1:0]        num_in_c;
  logic [31:0]             tex_code_c;
  logic                    bypass_c;
  logic [SEL_W-1:0]        sel_in_c;
  logic                    unused_c;

  assign hs_c       = req_valid_in && req_ready_out;
  assign u_shift_c  = wallX_in[7:0] >> (8 - TEX_W_LOG2);
  assign u_in_c     = flip_in ? ~u_shift_c[TEX_W_LOG2-1:0] : u_shift_c[TEX_W_LOG2-1:0];
  assign off_c      = ({2'b00, vcount_ray_in} < drawstart_in) ? 10'd0
                                                              : {2'b00, vcount_ray_in} - drawstart_in;
  assign num_in_c   = {off_c, {TEX_H_LOG2{1'b0}}};
  assign tex_code_c = 32'(texture_in);
  assign bypass_c   = (tex_code_c < TEX_ID_BASE) || (tex_code_c >= TEX_ID_BASE + NUM_TEX)
                      || (lineheight_in == 8'd0);
  assign sel_in_c   = SEL_W'(tex_code_c - TEX_ID_BASE);
  assign unused_c   = ^wallX_in[15:8];

  // One restoring-division step; the remainder always stays below the 8-bit divisor
  logic [8:0]              trial_c;
  logic                    qbit_c;
  logic [7:0]              rem_next_c;
  logic [NUM_W-1:0]        quo_next_c;
  logic [TEX_H_LOG2-1:0]   v_c;

  assign trial_c    = {rem_q, num_q[NUM_W-1]};
  assign qbit_c     = trial_c >= {1'b0, div_q};
  assign rem_next_c = qbit_c ? 8'(trial_c - {1'b0, div_q}) : trial_c[7:0];
  assign quo_next_c = {quo_q[NUM_W-2:0], qbit_c};
  assign v_c        = (quo_next_c > NUM_W'(TEX_H - 1)) ? TEX_H_LOG2'(TEX_H - 1)
                                                        : TEX_H_LOG2'(quo_next_c);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    u_d       = u_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    addr_d    = rom_addr_out;
    rom_sel_d = rom_sel_out;
    rom_en_d  = 1'b0;
    pix_d     = tex_pixel_out;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs_c) begin
          num_d = num_in_c;
          quo_d = '0;
          rem_d = '0;
          div_d = lineheight_in;
          u_d   = u_in_c;
          sel_d = sel_in_c;
          cnt_d = '0;
          if (bypass_c) begin
            pix_d   = '0;
            state_d = OUT;
          end else begin
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        num_d = num_q << 1;
        rem_d = rem_next_c;
        quo_d = quo_next_c;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_W'(NUM_W - 1)) begin
          addr_d    = {v_c, u_q};
          rom_sel_d = sel_q;
          rom_en_d  = 1'b1;
          cnt_d     = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_W'(ROM_LATENCY - 1)) begin
          pix_d   = rom_data_in;
          cnt_d   = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        // valid rises one cycle after entering OUT; release only once it is seen
        valid_d = 1'b1;
        if (valid_tex_out && out_ready_in) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      num_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      div_q         <= '0;
      u_q           <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      rom_addr_out  <= '0;
      rom_sel_out   <= '0;
      rom_en_out    <= 1'b0;
      tex_pixel_out <= '0;
      valid_tex_out <= 1'b0;
      req_ready_out <= 1'b1;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      div_q         <= div_d;
      u_q           <= u_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      rom_addr_out  <= addr_d;
      rom_sel_out   <= rom_sel_d;
      rom_en_out    <= rom_en_d;
      tex_pixel_out <= pix_d;
      valid_tex_out <= valid_d;
      req_ready_out <= ready_d;
    end
  end

endmodule

// File: tb/tb_tex_sampler.sv
// Randomized and directed bench for tex_sampler against an arithmetic model of the
// texel address, ROM select, bypass rule and handshake latency.
module tb_tex_sampler;

  localparam int unsigned TW = 7;
  localparam int unsigned TH = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] wallx;
  logic        flip;
  logic [7:0]  lineheight;
  logic [9:0]  drawstart;
  logic [7:0]  vcount;
  logic [3:0]  texture;
  logic [13:0] rom_addr;
  logic [1:0]  rom_sel;
  logic        rom_en;
  logic [7:0]  rom_data;
  logic [7:0]  tex_pixel;
  logic        valid_tex;
  logic        out_ready;
  bit          rom_fixed = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tex_sampler dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .req_valid_in (req_valid),
    .req_ready_out(req_ready),
    .wallX_in     (wallx),
    .flip_in      (flip),
    .lineheight_in(lineheight),
    .drawstart_in (drawstart),
    .vcount_ray_in(vcount),
    .texture_in   (texture),
    .rom_addr_out (rom_addr),
    .rom_sel_out  (rom_sel),
    .rom_en_out   (rom_en),
    .rom_data_in  (rom_data),
    .tex_pixel_out(tex_pixel),
    .valid_tex_out(valid_tex),
    .out_ready_in (out_ready)
  );

  function automatic logic [7:0] rom_val(input int unsigned sel, input int unsigned addr);
    return 8'((addr * 7) ^ (addr >> 6) ^ (sel * 53) ^ 8'h3C);
  endfunction

  assign rom_data = rom_fixed ? 8'h5A : rom_val(32'(rom_sel), 32'(rom_addr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: texel coordinates from the mapping rules, with plain integer arithmetic
  task automatic model(input logic [15:0] wx, input bit fl, input int unsigned lh,
                       input int unsigned ds, input int unsigned vc, input int unsigned tx,
                       output int unsigned addr, output int unsigned sel, output bit byp);
    int unsigned u, off, q, v;
    u = (int'(wx) & 255) / (1 << (8 - TW));
    if (fl) u = (1 << TW) - 1 - u;
    off = (vc < ds) ? 0 : vc - ds;
    q   = (lh == 0) ? 0 : (off * (1 << TH)) / lh;
    v   = (q > (1 << TH) - 1) ? (1 << TH) - 1 : q;
    addr = v * (1 << TW) + u;
    sel  = (tx - 3) & 3;
    byp  = (tx < 3) || (tx > 6) || (lh == 0);
  endtask

  task automatic scramble_inputs();
    wallx      = 16'($urandom);
    flip       = 1'($urandom);
    lineheight = 8'($urandom);
    drawstart  = 10'($urandom);
    vcount     = 8'($urandom);
    texture    = 4'($urandom);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (w >= 60) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic run_req(input logic [15:0] wx, input bit fl, input logic [7:0] lh,
                         input logic [9:0] ds, input logic [7:0] vc, input logic [3:0] tx,
                         input int bp, input bit early);
    int unsigned ea, es;
    bit          byp;
    int          vk, ek, en_cnt, bad;
    logic [13:0] ga;
    logic [1:0]  gs;
    logic [7:0]  ep;
    model(wx, fl, 32'(lh), 32'(ds), 32'(vc), 32'(tx), ea, es, byp);
    ep = byp ? 8'h00 : (rom_fixed ? 8'h5A : rom_val(es, ea));
    wait_ready();
    wallx = wx; flip = fl; lineheight = lh; drawstart = ds; vcount = vc; texture = tx;
    req_valid = 1'b1;
    out_ready = early;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_inputs();
    vk = -1; ek = -1; en_cnt = 0; ga = '0; gs = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) check("ready_busy", 32'(req_ready), 32'd0);
      if (rom_en) begin
        en_cnt++;
        if (ek < 0) begin ek = k; ga = rom_addr; gs = rom_sel; end
      end
      if (valid_tex) begin vk = k; break; end
    end
    check("valid_latency", 32'(vk), byp ? 32'd1 : 32'd20);
    check("rom_en_pulses", 32'(en_cnt), byp ? 32'd0 : 32'd1);
    if (!byp && ek >= 0) begin
      check("rom_en_cycle", 32'(ek), 32'd17);
      check("rom_addr", 32'(ga), ea);
      check("rom_sel", 32'(gs), es);
    end
    check("pixel", 32'(tex_pixel), 32'(ep));
    if (vk >= 0) begin
      if (!early) begin
        bad = 0;
        for (int i = 0; i < bp; i++) begin
          @(negedge clk);
          if (valid_tex !== 1'b1 || tex_pixel !== ep || req_ready !== 1'b0) bad++;
        end
        check("backpressure_hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
      end
      @(negedge clk);
      check("release_ready", 32'(req_ready), 32'd1);
      check("release_valid", 32'(valid_tex), 32'd0);
    end
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_valid"}, 32'(valid_tex), 32'd0);
    check({tag, "_pixel"}, 32'(tex_pixel), 32'd0);
    check({tag, "_en"},    32'(rom_en),    32'd0);
    check({tag, "_addr"},  32'(rom_addr),  32'd0);
    check({tag, "_sel"},   32'(rom_sel),   32'd0);
  endtask

  // Launch a request, pull reset after dly cycles, and confirm it never completes
  task automatic reset_abort(input int dly);
    int seen = 0;
    wait_ready();
    wallx = 16'h00C0; flip = 1'b0; lineheight = 8'd90; drawstart = 10'd5;
    vcount = 8'd77; texture = 4'd5; req_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (dly) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid_tex) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal texel with a fixed ROM value
    rom_fixed = 1'b1;
    run_req(16'h0080, 1'b0, 8'd120, 10'd40, 8'd100, 4'd3, 0, 1'b0);
    rom_fixed = 1'b0;
    // Clamp of v plus horizontal flip
    run_req(16'h00FF, 1'b1, 8'd100, 10'd0, 8'd150, 4'd6, 0, 1'b0);
    // Bypass: texture beyond range, and zero wall height
    run_req(16'h1234, 1'b0, 8'd50, 10'd3, 8'd60, 4'd7, 0, 1'b0);
    run_req(16'h0042, 1'b0, 8'd0, 10'd3, 8'd60, 4'd4, 0, 1'b0);
    run_req(16'h0042, 1'b1, 8'd30, 10'd3, 8'd60, 4'd2, 2, 1'b0);
    // Backpressure for ten cycles
    run_req(16'h0033, 1'b0, 8'd64, 10'd20, 8'd90, 4'd5, 10, 1'b0);
    // Row above the wall start
    run_req(16'h005B, 1'b0, 8'd80, 10'd40, 8'd10, 4'd4, 0, 1'b1);
    // Downstream already ready: the pixel is still presented for one cycle
    run_req(16'h00A1, 1'b1, 8'd1, 10'd0, 8'd255, 4'd6, 0, 1'b1);

    reset_abort(5);
    run_req(16'h0071, 1'b0, 8'd200, 10'd12, 8'd180, 4'd3, 1, 1'b0);
    reset_abort(18);
    run_req(16'h00E7, 1'b1, 8'd17, 10'd100, 8'd111, 4'd5, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] tx;
      logic [7:0] lh;
      tx = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(3, 6)) : 4'($urandom);
      lh = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_req(16'($urandom), 1'($urandom), lh, 10'($urandom_range(0, 300)),
              8'($urandom), tx, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
